nubus_slave_ctrl: RTL and testbench

- NuBus slave responder for the card's slot space ($Fs000000–$FsFFFFFF, s = slot ID).
- Decodes START address/transfer-mode cycles and converts each single-beat NuBus transaction into one request on a simple local memory bus.
- Returns ACK with status and read data on the bus.
- Sits between the 3.3 V-side bus transceivers and the card's memory/ROM/register fabric; complements the card's NuBus master engine.

---
 rtl/nubus_slave_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_nubus_slave_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nubus_slave_ctrl.sv
// NuBus slot-space slave: turns each single-beat NuBus transaction into one
// local memory request and answers with ACK, status and read data.
module nubus_slave_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MIN_WAIT       = 1
) (
    input  logic        clk_3v3,
    input  logic        reset_3v3_n,
    input  logic [3:0]  id_3v3_n,
    input  logic        start_3v3_n,
    input  logic        tm0_3v3_n,
    input  logic        tm1_3v3_n,
    input  logic [31:0] ad_3v3_n,
    output logic        ack_o_n,
    output logic        ack_oe_n,
    output logic        tm0_o_n,
    output logic        tm1_o_n,
    output logic        tmx_oe_n,
    output logic [31:0] ad_o_n,
    output logic        nubus_oe,
    output logic        nubus_ad_dir,
    output logic        mem_valid,
    output logic [21:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        mem_err,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, DATA, REQ, ACK} state_t;

    localparam logic [8:0] MIN_W = 9'(MIN_WAIT);
    localparam logic [8:0] TO_W  = 9'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [21:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        unsup_q, unsup_d;
    logic [31:0] wdata_q, wdata_d;
    logic        valid_q, valid_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        got_q, got_d;
    logic        err_q, err_d;
    logic        tout_q, tout_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  lane_a;
    logic [3:0]  dec_strb;
    logic        dec_unsup;
    logic        selected;
    logic [8:0]  req_cycles;
    logic        ack_now;
    logic        done;
    logic        in_ack;
    logic        rd_ok;
    logic [31:0] lane_mask;

    assign lane_a     = ~ad_3v3_n[1:0];
    assign selected   = !start_3v3_n && (~ad_3v3_n[31:24] == {4'hF, ~id_3v3_n});
    assign req_cycles = {1'b0, cnt_q} + 9'd1;
    assign ack_now    = valid_q && mem_ack;
    assign done       = got_q || ack_now;

    always_comb begin
        dec_strb  = 4'b0000;
        dec_unsup = 1'b0;
        if (!tm0_3v3_n) begin
            dec_strb = 4'b0001 << lane_a;
        end else begin
            case (lane_a)
                2'b11:   dec_strb = 4'b1111;
                2'b10:   dec_strb = 4'b1100;
                2'b00:   dec_strb = 4'b0011;
                default: dec_unsup = 1'b1;   // block transfers are not served
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        unsup_d = unsup_q;
        wdata_d = wdata_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        got_d   = got_q;
        err_d   = err_q;
        tout_d  = tout_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (selected) begin
                    state_d = DATA;
                    addr_d  = ~ad_3v3_n[23:2];
                    we_d    = !tm1_3v3_n;
                    wstrb_d = dec_strb;
                    unsup_d = dec_unsup;
                    cnt_d   = 8'd0;
                    got_d   = 1'b0;
                    err_d   = 1'b0;
                    tout_d  = 1'b0;
                end
            end
            DATA: begin
                if (we_q) wdata_d = ~ad_3v3_n;
                if (unsup_q) begin
                    state_d = ACK;
                    err_d   = 1'b1;
                end else begin
                    state_d = REQ;
                    valid_d = 1'b1;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (ack_now) begin
                    got_d   = 1'b1;
                    valid_d = 1'b0;
                    err_d   = mem_err;
                    rdata_d = mem_rdata;
                end
                if (done && req_cycles >= MIN_W) begin
                    state_d = ACK;
                end else if (!done && req_cycles >= TO_W) begin
                    state_d = ACK;
                    tout_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_3v3 or negedge reset_3v3_n) begin
        if (!reset_3v3_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            unsup_q <= 1'b0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            got_q   <= 1'b0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            unsup_q <= unsup_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            got_q   <= got_d;
            err_q   <= err_d;
            tout_q  <= tout_d;
            rdata_q <= rdata_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_mask[gi*8 +: 8] = {8{wstrb_q[gi]}};
    end

    // Bus drivers decode from the state register so reset releases them at once.
    assign in_ack       = (state_q == ACK);
    assign rd_ok        = in_ack && !we_q && !err_q && !tout_q;
    assign ack_o_n      = !in_ack;
    assign ack_oe_n     = !in_ack;
    assign tmx_oe_n     = !in_ack;
    assign tm1_o_n      = !(in_ack && tout_q);
    assign tm0_o_n      = !(in_ack && err_q && !tout_q);
    assign ad_o_n       = rd_ok ? ~(rdata_q & lane_mask) : '1;
    assign nubus_ad_dir = rd_ok;
    assign nubus_oe     = 1'b0;

    assign mem_valid = valid_q;
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wstrb = wstrb_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_nubus_slave_ctrl.sv
// Scoreboard bench for nubus_slave_ctrl: expected memory requests and ACKs are
// queued as each transaction is driven and consumed by two monitors.
module tb_nubus_slave_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  id_n = ~4'hC;
    logic        start_n = 1'b1;
    logic        tm0_n = 1'b1;
    logic        tm1_n = 1'b1;
    logic [31:0] ad_n = '1;
    logic        ack_o_n, ack_oe_n, tm0_o_n, tm1_o_n, tmx_oe_n;
    logic [31:0] ad_o_n;
    logic        nubus_oe, nubus_ad_dir;
    logic        mem_valid, mem_we;
    logic [21:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack, mem_err;
    logic [31:0] mem_rdata;

    nubus_slave_ctrl #(.TIMEOUT_CYCLES(TO), .MIN_WAIT(1)) dut (
        .clk_3v3(clk), .reset_3v3_n(reset_n), .id_3v3_n(id_n),
        .start_3v3_n(start_n), .tm0_3v3_n(tm0_n), .tm1_3v3_n(tm1_n),
        .ad_3v3_n(ad_n), .ack_o_n(ack_o_n), .ack_oe_n(ack_oe_n),
        .tm0_o_n(tm0_o_n), .tm1_o_n(tm1_o_n), .tmx_oe_n(tmx_oe_n),
        .ad_o_n(ad_o_n), .nubus_oe(nubus_oe), .nubus_ad_dir(nubus_ad_dir),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_err(mem_err), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [21:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] ad;
        logic        dir;
        logic [7:0]  lat;
    } ack_t;

    req_t req_q[$];
    ack_t ack_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int acks_seen = 0;
    int resp_delay = -1;
    logic [31:0] resp_rdata = '0;
    logic resp_err = 1'b0;
    logic force_ack = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Memory responder and request checker.
    initial begin
        int rc;
        bit in_req;
        req_t e;
        rc = 0;
        in_req = 0;
        mem_ack = 1'b0;
        mem_err = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack = force_ack;
            mem_err = 1'b0;
            if (mem_valid) begin
                if (!in_req) begin
                    in_req = 1;
                    rc = 0;
                    if (req_q.size() == 0) begin
                        check_eq("req_unexpected", 1, 0);
                    end else begin
                        e = req_q.pop_front();
                        check_eq("mem_addr", mem_addr, e.addr);
                        check_eq("mem_we", mem_we, e.we);
                        check_eq("mem_wstrb", mem_wstrb, e.strb);
                        if (e.we) check_eq("mem_wdata", mem_wdata, e.wdata);
                    end
                end
                rc++;
                if (rc == resp_delay) begin
                    mem_ack = 1'b1;
                    mem_err = resp_err;
                    mem_rdata = resp_rdata;
                end
            end else begin
                in_req = 0;
            end
        end
    end

    // ACK checker: one-cycle ACK, then drivers released on the following cycle.
    initial begin
        bit rel_pending;
        ack_t e;
        rel_pending = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rel_pending) begin
                check_eq("ack_released", {ack_oe_n, tmx_oe_n, nubus_ad_dir}, 3'b110);
                rel_pending = 0;
            end
            if (!ack_oe_n) begin
                if (ack_q.size() == 0) begin
                    check_eq("ack_unexpected", 1, 0);
                end else begin
                    e = ack_q.pop_front();
                    check_eq("ack_o_n", {ack_o_n, tmx_oe_n}, 2'b00);
                    check_eq("ack_status", {tm1_o_n, tm0_o_n}, e.st);
                    check_eq("ack_ad", ad_o_n, e.ad);
                    check_eq("ack_dir", nubus_ad_dir, e.dir);
                    check_eq("ack_latency", cyc - start_cyc, e.lat);
                end
                acks_seen++;
                rel_pending = 1;
            end
        end
    end

    function automatic logic [4:0] model_strb(input logic [1:0] a, input bit t0);
        // {unsupported, strobe}
        if (t0) begin
            case (a)
                2'd0: return 5'b0_0001;
                2'd1: return 5'b0_0010;
                2'd2: return 5'b0_0100;
                default: return 5'b0_1000;
            endcase
        end
        case (a)
            2'd3: return 5'b0_1111;
            2'd2: return 5'b0_1100;
            2'd0: return 5'b0_0011;
            default: return 5'b1_0000;
        endcase
    endfunction

    function automatic logic [31:0] model_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic drive_start_data(input logic [31:0] addr, input bit wr, input bit t0,
                                    input logic [31:0] wdata);
        start_n = 1'b0;
        ad_n = ~addr;
        tm1_n = wr ? 1'b0 : 1'b1;
        tm0_n = t0 ? 1'b0 : 1'b1;
        start_cyc = cyc;
        step();
        start_n = 1'b1;
        tm0_n = 1'b1;
        tm1_n = 1'b1;
        ad_n = wr ? ~wdata : '1;
        step();
        ad_n = '1;
    endtask

    task automatic txn(input logic [31:0] addr, input bit wr, input bit t0,
                       input logic [31:0] wdata, input int delay,
                       input logic [31:0] rdata, input bit err, input bit busy);
        logic [4:0] m;
        bit sel;
        int n0;
        req_t r;
        ack_t k;
        m = model_strb(addr[1:0], t0);
        sel = (addr[31:24] == 8'hFC);
        if (sel && !m[4]) begin
            r.addr = addr[23:2];
            r.we = wr;
            r.strb = m[3:0];
            r.wdata = wdata;
            req_q.push_back(r);
        end
        if (sel) begin
            k.ad = '1;
            k.dir = 1'b0;
            if (m[4]) begin
                k.st = 2'b10;
                k.lat = 8'd2;
            end else if (delay < 0) begin
                k.st = 2'b01;
                k.lat = 8'(2 + TO);
            end else begin
                k.st = err ? 2'b10 : 2'b11;
                k.lat = 8'(2 + delay);
                if (!wr && !err) begin
                    k.ad = ~(rdata & model_mask(m[3:0]));
                    k.dir = 1'b1;
                end
            end
            ack_q.push_back(k);
        end
        resp_delay = delay;
        resp_rdata = rdata;
        resp_err = err;
        n0 = acks_seen;
        drive_start_data(addr, wr, t0, wdata);
        if (busy) begin
            start_n = 1'b0;
            ad_n = ~addr;
            step();
            start_n = 1'b1;
            ad_n = '1;
        end
        for (int i = 0; i < 40 && acks_seen == n0; i++) step();
        step();
        step();
        check_eq(sel ? "ack_count" : "no_ack", acks_seen - n0, sel ? 1 : 0);
        check_eq("req_drained", req_q.size(), 0);
        check_eq("ack_drained", ack_q.size(), 0);
        $display("txn addr=%08h we=%0d t0=%0d delay=%0d err=%0d total=%0d bad=%0d",
                 addr, wr, t0, delay, err, total, bad);
    endtask

    initial begin
        logic [31:0] sweep_addr[6];
        logic [31:0] rd;
        sweep_addr = '{32'hFC000004, 32'hFC00000A, 32'hFC00000C,
                       32'hFC000011, 32'hFC000016, 32'hFC00001B};
        sweep_addr[1] = 32'hFC00000A;
        repeat (3) step();
        check_eq("rst_oe", {ack_oe_n, tmx_oe_n, ack_o_n, tm1_o_n, tm0_o_n}, 5'b11111);
        check_eq("rst_ad", ad_o_n, 32'hFFFFFFFF);
        check_eq("rst_dir_oe", {nubus_ad_dir, nubus_oe}, 2'b00);
        check_eq("rst_mem", {mem_valid, mem_we, mem_wstrb, mem_addr, mem_wdata}, 64'd0);
        reset_n = 1'b1;
        step();

        txn(32'hFC000000, 1, 0, 32'h87654321, 2, 32'h0, 0, 0);
        txn(32'hFC000003, 0, 0, 32'h0, 1, 32'h87654321, 0, 0);

        // Half/byte lanes: t0 flag 0 for the two halves, 1 for the four bytes.
        for (int i = 0; i < 6; i++)
            txn(sweep_addr[i], 1, (i >= 2), 32'h11223344 + i, 1 + (i % 3), 32'h0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            rd = $urandom;
            txn(sweep_addr[i], 0, (i >= 2), 32'h0, 1 + (i % 2), rd, 0, 0);
        end

        txn(32'hFB000000, 1, 0, 32'hDEADBEEF, 1, 32'h0, 0, 0);
        txn(32'hFC000021, 0, 0, 32'h0, 1, 32'h0, 0, 0);
        txn(32'hFC000040, 0, 0, 32'h0, 2, 32'hCAFEF00D, 1, 0);
        txn(32'hFC000044, 1, 0, 32'h5A5A5A5A, 4, 32'h0, 0, 1);

        txn(32'hFC000080, 0, 0, 32'h0, -1, 32'h0, 0, 0);
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        repeat (4) step();
        txn(32'hFC000084, 1, 0, 32'h0BADF00D, 1, 32'h0, 0, 0);

        // Reset pulse while a request is outstanding.
        r_rst: begin
            req_t r;
            r.addr = 22'h000030;
            r.we = 1'b0;
            r.strb = 4'b1111;
            r.wdata = '0;
            req_q.push_back(r);
            resp_delay = -1;
            drive_start_data(32'hFC0000C3, 0, 0, 32'h0);
            step();
            check_eq("pre_rst_valid", mem_valid, 1'b1);
            #3 reset_n = 1'b0;
            #1;
            check_eq("rst_mid_oe", {ack_oe_n, tmx_oe_n, nubus_ad_dir, mem_valid}, 4'b1100);
            check_eq("rst_mid_ad", ad_o_n, 32'hFFFFFFFF);
            step();
            step();
            reset_n = 1'b1;
            step();
        end
        txn(32'hFC0000C3, 0, 0, 32'h0, 1, 32'h13572468, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
